// File: rtl/multistart_descent_sequencer.sv
// Multi-start descent sequencer: queues Q24.8 seeds, runs one descent per seed, keeps the batch-wide best result.
// start_op rises 2 cycles after an accepted run; seed_ready drops when full. Define GD_TIMEOUT_EN for a per-seed watchdog.
module multistart_descent_sequencer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_valid,
    input  logic [31:0]      seed_data,
    output logic             seed_ready,
    input  logic             run,
    output logic             busy,
    output logic             batch_done,
    output logic             start_op,
    output logic [31:0]      x_init,
    input  logic             done_op,
    input  logic [31:0]      x_at_min,
    input  logic [63:0]      y_min,
    output logic [31:0]      best_x,
    output logic [63:0]      best_y,
    output logic [CNT_W-1:0] best_idx,
    output logic [CNT_W-1:0] seed_count,
    output logic             timeout_err
);
    localparam int          PTR_W = $clog2(FIFO_DEPTH);
    localparam int          OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [63:0] Y_MAX = 64'h7FFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LAUNCH,
        S_COLLECT,
        S_RELEASE,
        S_FINISH
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic             fifo_full, fifo_empty, push, pop;

    logic [31:0]      x_init_q, x_init_d;
    logic             start_op_q, start_op_d;
    logic [31:0]      best_x_q, best_x_d;
    logic [63:0]      best_y_q, best_y_d;
    logic [CNT_W-1:0] best_idx_q, best_idx_d;
    logic [CNT_W-1:0] seed_count_q, seed_count_d;

`ifdef GD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_err_q, timeout_err_d;
    logic            wd_expired;

    // wd_q holds the number of LAUNCH cycles already spent on this seed
    assign wd_expired  = (wd_q >= WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_err_q;
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign timeout_err        = 1'b0;
`endif

    assign fifo_full  = (occ_q == OCC_W'(FIFO_DEPTH));
    assign fifo_empty = (occ_q == '0);
    assign seed_ready = !fifo_full;
    assign push       = seed_valid && !fifo_full;
    assign pop        = (state_q == S_POP) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= seed_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        x_init_d     = x_init_q;
        start_op_d   = start_op_q;
        best_x_d     = best_x_q;
        best_y_d     = best_y_q;
        best_idx_d   = best_idx_q;
        seed_count_d = seed_count_q;
`ifdef GD_TIMEOUT_EN
        wd_d          = wd_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (run && !fifo_empty) begin
                    state_d      = S_POP;
                    seed_count_d = '0;
                    best_y_d     = Y_MAX;
                    best_x_d     = '0;
                    best_idx_d   = '0;
`ifdef GD_TIMEOUT_EN
                    timeout_err_d = 1'b0;
`endif
                end
            end
            S_POP: begin
                x_init_d = mem_q[rd_ptr_q];
                state_d  = S_LAUNCH;
`ifdef GD_TIMEOUT_EN
                wd_d = '0;
`endif
            end
            S_LAUNCH: begin
                start_op_d = 1'b1;
                if (done_op) begin
                    state_d = S_COLLECT;
                end
`ifdef GD_TIMEOUT_EN
                else if (wd_expired) begin
                    // abandon this seed without touching the best result
                    start_op_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    seed_count_d  = seed_count_q + CNT_W'(1);
                    state_d       = S_RELEASE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            S_COLLECT: begin
                // strict less-than so a tie keeps the earlier seed
                if ($signed(y_min) < $signed(best_y_q)) begin
                    best_y_d   = y_min;
                    best_x_d   = x_at_min;
                    best_idx_d = seed_count_q;
                end
                seed_count_d = seed_count_q + CNT_W'(1);
                start_op_d   = 1'b0;
                state_d      = S_RELEASE;
            end
            S_RELEASE: begin
                if (!done_op) begin
                    state_d = fifo_empty ? S_FINISH : S_POP;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            x_init_q     <= '0;
            start_op_q   <= 1'b0;
            best_x_q     <= '0;
            best_y_q     <= Y_MAX;
            best_idx_q   <= '0;
            seed_count_q <= '0;
`ifdef GD_TIMEOUT_EN
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            x_init_q     <= x_init_d;
            start_op_q   <= start_op_d;
            best_x_q     <= best_x_d;
            best_y_q     <= best_y_d;
            best_idx_q   <= best_idx_d;
            seed_count_q <= seed_count_d;
`ifdef GD_TIMEOUT_EN
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign batch_done = (state_q == S_FINISH);
    assign start_op   = start_op_q;
    assign x_init     = x_init_q;
    assign best_x     = best_x_q;
    assign best_y     = best_y_q;
    assign best_idx   = best_idx_q;
    assign seed_count = seed_count_q;

endmodule

// File: tb/tb_multistart_descent_sequencer.sv
// Bench for multistart_descent_sequencer: scoreboarded seeds, a descent-top stub, and batch-level result checks.
module tb_multistart_descent_sequencer;
    localparam int DEPTH = 8;
    localparam int CW    = 8;
`ifdef GD_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 4096;
`endif
    localparam logic [63:0] Y_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] XK    = 32'h0000_5A00;  // stub answers x_at_min = x_init ^ XK

    logic          clk, rst_n;
    logic          seed_valid, seed_ready, run, busy, batch_done;
    logic [31:0]   seed_data, x_init, x_at_min, best_x;
    logic          start_op, done_op, timeout_err;
    logic [63:0]   y_min, best_y;
    logic [CW-1:0] best_idx, seed_count;

    multistart_descent_sequencer #(
        .FIFO_DEPTH    (DEPTH),
        .CNT_W         (CW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_valid (seed_valid),
        .seed_data  (seed_data),
        .seed_ready (seed_ready),
        .run        (run),
        .busy       (busy),
        .batch_done (batch_done),
        .start_op   (start_op),
        .x_init     (x_init),
        .done_op    (done_op),
        .x_at_min   (x_at_min),
        .y_min      (y_min),
        .best_x     (best_x),
        .best_y     (best_y),
        .best_idx   (best_idx),
        .seed_count (seed_count),
        .timeout_err(timeout_err)
    );

    int n_vec    = 0;
    int n_miscmp = 0;

    logic [31:0] exp_x_q[$];
    logic [63:0] rsp_y_q[$];
    bit          rsp_hang_q[$];
    logic [31:0] bat_x[$];
    logic [63:0] bat_y[$];
    bit          bat_hang[$];
    int          model_occ  = 0;
    int          launches   = 0;
    int          hold_extra = 0;

    logic [31:0]   exp_bx;
    logic [63:0]   exp_by;
    logic [CW-1:0] exp_bi, exp_sc;
    logic          exp_to;

    logic [63:0] stub_y;
    bit          stub_hang;
    int          stub_w;
    logic        start_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_rst(input string tag);
        check_eq({tag, "_start_op"},   64'(start_op),    64'(0));
        check_eq({tag, "_x_init"},     64'(x_init),      64'(0));
        check_eq({tag, "_busy"},       64'(busy),        64'(0));
        check_eq({tag, "_batch_done"}, 64'(batch_done),  64'(0));
        check_eq({tag, "_best_x"},     64'(best_x),      64'(0));
        check_eq({tag, "_best_y"},     best_y,           Y_MAX);
        check_eq({tag, "_best_idx"},   64'(best_idx),    64'(0));
        check_eq({tag, "_seed_count"}, 64'(seed_count),  64'(0));
        check_eq({tag, "_timeout"},    64'(timeout_err), 64'(0));
        check_eq({tag, "_seed_ready"}, 64'(seed_ready),  64'(1));
    endtask

    // call at posedge+1; the model decides acceptance from its own occupancy count
    task automatic push_seed(input logic [31:0] x, input logic [63:0] y, input bit hang);
        seed_valid = 1'b1;
        seed_data  = x;
        check_eq("seed_ready", 64'(seed_ready), 64'(model_occ < DEPTH));
        if (model_occ < DEPTH) begin
            model_occ++;
            exp_x_q.push_back(x);
            rsp_y_q.push_back(y);
            rsp_hang_q.push_back(hang);
            bat_x.push_back(x ^ XK);
            bat_y.push_back(y);
            bat_hang.push_back(hang);
        end
        @(posedge clk); #1;
        seed_valid = 1'b0;
    endtask

    task automatic run_batch(input string tag);
        int n, cyc, dones;
        bit saw_busy;
        n = bat_y.size();
        if (n > 0) begin
            exp_by = Y_MAX; exp_bx = '0; exp_bi = '0; exp_sc = CW'(n); exp_to = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (bat_hang[i]) exp_to = 1'b1;
                else if ($signed(bat_y[i]) < $signed(exp_by)) begin
                    exp_by = bat_y[i]; exp_bx = bat_x[i]; exp_bi = CW'(i);
                end
            end
        end
        launches = 0;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        check_eq({tag, "_start_t0"}, 64'(start_op), 64'(0));
        @(posedge clk); #1;
        check_eq({tag, "_start_t1"}, 64'(start_op), 64'(0));
        @(posedge clk); #1;
        check_eq({tag, "_start_t2"}, 64'(start_op), 64'(n > 0));
        cyc = 0; dones = 0; saw_busy = 1'b0;
        do begin
            if (batch_done) dones++;
            if (busy) saw_busy = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end while (cyc < 4000 && !(n > 0 && dones > 0) && !(n == 0 && cyc >= 10));
        repeat (3) begin
            if (batch_done) dones++;
            @(posedge clk); #1;
        end
        check_eq({tag, "_batch_done_cnt"}, 64'(dones),       64'(n > 0));
        check_eq({tag, "_busy_seen"},      64'(saw_busy),    64'(n > 0));
        check_eq({tag, "_busy_end"},       64'(busy),        64'(0));
        check_eq({tag, "_launches"},       64'(launches),    64'(n));
        check_eq({tag, "_best_x"},         64'(best_x),      64'(exp_bx));
        check_eq({tag, "_best_y"},         best_y,           exp_by);
        check_eq({tag, "_best_idx"},       64'(best_idx),    64'(exp_bi));
        check_eq({tag, "_seed_count"},     64'(seed_count),  64'(exp_sc));
        check_eq({tag, "_timeout"},        64'(timeout_err), 64'(exp_to));
        model_occ = 0;
        bat_x.delete(); bat_y.delete(); bat_hang.delete();
    endtask

    // descent-top stub: answers each launch after 2 cycles, holds done_op hold_extra cycles past start_op falling
    initial begin
        done_op = 1'b0; x_at_min = '0; y_min = '0;
        forever begin
            @(posedge clk); #1;
            if (start_op) begin
                launches++;
                check_eq("launch_expected", 64'(exp_x_q.size() > 0), 64'(1));
                stub_y = '0; stub_hang = 1'b0;
                if (exp_x_q.size() > 0) begin
                    check_eq("x_init_order", 64'(x_init), 64'(exp_x_q.pop_front()));
                    stub_y    = rsp_y_q.pop_front();
                    stub_hang = rsp_hang_q.pop_front();
                end
                repeat (2) @(posedge clk);
                if (!stub_hang) begin
                    @(negedge clk);
                    x_at_min = x_init ^ XK;
                    y_min    = stub_y;
                    done_op  = 1'b1;
                end
                stub_w = 0;
                @(posedge clk); #1;
                while (start_op && stub_w < 200) begin
                    @(posedge clk); #1;
                    stub_w++;
                end
                check_eq("start_fall", 64'(start_op), 64'(0));
                repeat (hold_extra) @(posedge clk);
                @(negedge clk);
                done_op = 1'b0;
            end
        end
    end

    // start_op may only rise while the descent top reports idle
    initial begin
        forever begin
            @(posedge clk); #1;
            if (start_op && !start_prev) check_eq("start_rise_done_low", 64'(done_op), 64'(0));
            start_prev = start_op;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int w;
        rst_n = 1'b0; seed_valid = 1'b0; seed_data = '0; run = 1'b0;
        exp_bx = '0; exp_by = Y_MAX; exp_bi = '0; exp_sc = '0; exp_to = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_rst("rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_rst("rst_rel");

        // basic batch, tie on y=20 keeps seed 1
        hold_extra = 0;
        push_seed(32'h0000_0A00, 64'd50, 1'b0);
        push_seed(32'hFFFF_F600, 64'd20, 1'b0);
        push_seed(32'h0000_0100, 64'd20, 1'b0);
        run_batch("basic");

        // run with empty FIFO is ignored, results hold
        run_batch("empty");

        // overflow: 9th push with seed_valid held is dropped; slow done_op release
        hold_extra = 3;
        for (int i = 0; i < 9; i++) push_seed(32'(i) * 32'h111, 64'(i ^ 5) + 64'd10, 1'b0);
        run_batch("full");

        // signed compare
        hold_extra = 1;
        push_seed(32'h0000_0200, -64'sd5, 1'b0);
        push_seed(32'hFFFF_FF00, 64'h8000_0000_0000_0000, 1'b0);
        run_batch("neg");

`ifdef GD_TIMEOUT_EN
        push_seed(32'h0000_0300, 64'd1, 1'b1);
        push_seed(32'h0000_0400, 64'd7, 1'b0);
        run_batch("wdog");
`endif

        // async reset while launching
        push_seed(32'h0000_0500, 64'd3, 1'b0);
        push_seed(32'h0000_0600, 64'd4, 1'b0);
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        w = 0;
        while (!start_op && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check_eq("rstm_launch", 64'(start_op), 64'(1));
        #2 rst_n = 1'b0;
        #1 check_rst("rstm");
        repeat (8) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        exp_x_q.delete(); rsp_y_q.delete(); rsp_hang_q.delete();
        bat_x.delete(); bat_y.delete(); bat_hang.delete();
        model_occ = 0;
        exp_bx = '0; exp_by = Y_MAX; exp_bi = '0; exp_sc = '0; exp_to = 1'b0;
        run_batch("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
